// File: rtl/consolidation_arbiter.sv
// consolidation_arbiter: round-robin funnel of 2-bit symbols from NUM_REQ sources into one
// stream, BYTES_PER_GRANT whole bytes per grant. Optional stall watchdog: `define ARB_TIMEOUT_EN.
module consolidation_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int BYTES_PER_GRANT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [2*NUM_REQ-1:0]       src_din,
  input  logic [NUM_REQ-1:0]         src_din_en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [1:0]                 cons_din,
  output logic                       cons_din_en,
  output logic [$clog2(NUM_REQ)-1:0] cur_id,
  output logic                       byte_done,
  output logic                       timeout
);

  localparam int ID_W      = $clog2(NUM_REQ);
  localparam int SYM_TOTAL = 4 * BYTES_PER_GRANT;
  localparam int CNT_W     = $clog2(SYM_TOTAL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYM_TOTAL - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

`ifdef ARB_TIMEOUT_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_PAD   = 2'd2
  } state_t;
`else
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;
`endif

  state_t             r_state;
  state_t             w_next_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [ID_W-1:0]    r_cur_id;
  logic [ID_W-1:0]    r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_cons_din;
  logic               r_cons_en;
  logic               r_byte_done;

  logic [1:0]         w_sym [NUM_REQ];
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_sel_id;
  logic               w_sel_found;
  logic               w_start;
  logic               w_finish;
  logic               w_emit;
  logic [1:0]         w_emit_sym;
  logic               w_timeout;

`ifdef ARB_TIMEOUT_EN
  logic [3:0]         r_stall;
  logic               r_timeout;
`endif

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sym[i] = src_din[2*i +: 2];
    end
  end

  // Round-robin search starting at the pointer, which sits one past the last grantee.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_id    = r_ptr;
    w_idx       = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = ID_W'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_sel_found && req[w_idx]) begin
        w_sel_found = 1'b1;
        w_sel_id    = w_idx;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_finish     = 1'b0;
    w_emit       = 1'b0;
    w_emit_sym   = 2'b00;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sel_found) begin
          w_start      = 1'b1;
          w_next_state = S_GRANT;
        end
      end
      S_GRANT: begin
        if (src_din_en[r_cur_id]) begin
          w_emit     = 1'b1;
          w_emit_sym = w_sym[r_cur_id];
          if (r_cnt == LAST_CNT) begin
            w_finish     = 1'b1;
            w_next_state = S_IDLE;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_stall == 4'd15) begin
          w_next_state = S_PAD;
        end
`endif
      end
`ifdef ARB_TIMEOUT_EN
      // Zero symbols fill out the grant so downstream byte packing stays aligned.
      S_PAD: begin
        w_emit = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_finish     = 1'b1;
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_cur_id    <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_cons_din  <= 2'b00;
      r_cons_en   <= 1'b0;
      r_byte_done <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cons_en   <= w_emit;
      r_cons_din  <= w_emit_sym;
      r_byte_done <= w_emit && (r_cnt[1:0] == 2'b11);
      if (w_start) begin
        r_gnt    <= NUM_REQ'(1) << w_sel_id;
        r_cur_id <= w_sel_id;
        r_ptr    <= (w_sel_id == LAST_ID) ? '0 : w_sel_id + 1'b1;
        r_cnt    <= '0;
      end else if (w_finish) begin
        r_gnt <= '0;
        r_cnt <= '0;
      end else if (w_emit) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Counts consecutive granted cycles with no accepted symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if (w_start || w_emit || r_state != S_GRANT) begin
        r_stall <= '0;
      end else begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = w_timeout;
`endif

  assign gnt         = r_gnt;
  assign cur_id      = r_cur_id;
  assign cons_din    = r_cons_din;
  assign cons_din_en = r_cons_en;
  assign byte_done   = r_byte_done;

endmodule

// File: tb/tb_consolidation_arbiter.sv
// tb_consolidation_arbiter: per-cycle vector table for the default arbiter plus hand sequences
// for stall/watchdog (ARB_TIMEOUT_EN) and a BYTES_PER_GRANT=2 instance.
module tb_consolidation_arbiter;

  typedef struct {
    logic       rstN;
    logic [3:0] req;
    logic [3:0] en;
    logic [7:0] din;
    logic [3:0] eGnt;
    logic [1:0] eCid;
    logic       eEn;
    logic [1:0] eDin;
    logic       eBd;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] src_din;
  logic [3:0] src_din_en;
  logic [3:0] gnt;
  logic [1:0] cons_din;
  logic       cons_din_en;
  logic [1:0] cur_id;
  logic       byte_done;
  logic       timeout;

  logic [3:0] req2;
  logic [7:0] src_din2;
  logic [3:0] src_din_en2;
  logic [3:0] gnt2;
  logic [1:0] cons_din2;
  logic       cons_din_en2;
  logic [1:0] cur_id2;
  logic       byte_done2;
  logic       timeout2;

  int passCount;
  int checkCount;
  vec_t vecs[$];

  consolidation_arbiter #(.NUM_REQ(4), .BYTES_PER_GRANT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_din(src_din), .src_din_en(src_din_en),
    .gnt(gnt), .cons_din(cons_din), .cons_din_en(cons_din_en), .cur_id(cur_id),
    .byte_done(byte_done), .timeout(timeout)
  );

  consolidation_arbiter #(.NUM_REQ(4), .BYTES_PER_GRANT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .src_din(src_din2), .src_din_en(src_din_en2),
    .gnt(gnt2), .cons_din(cons_din2), .cons_din_en(cons_din_en2), .cur_id(cur_id2),
    .byte_done(byte_done2), .timeout(timeout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void addVec(logic rstN, logic [3:0] rq, logic [3:0] en, logic [7:0] din,
                                 logic [3:0] eGnt, logic [1:0] eCid, logic eEn,
                                 logic [1:0] eDin, logic eBd);
    vecs.push_back('{rstN, rq, en, din, eGnt, eCid, eEn, eDin, eBd});
  endfunction

  function automatic void compare(string name, logic [10:0] act, logic [10:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: gnt/cid/en/din/bd/to got %b, expected %b", name, act, exp);
  endfunction

  // cons_din is only meaningful while cons_din_en is expected high
  task automatic checkOutput(string name, logic [3:0] eGnt, logic [1:0] eCid, logic eEn,
                             logic [1:0] eDin, logic eBd, logic eTo);
    compare(name, {gnt, cur_id, cons_din_en, (eEn ? cons_din : 2'b00), byte_done, timeout},
            {eGnt, eCid, eEn, (eEn ? eDin : 2'b00), eBd, eTo});
  endtask

  task automatic checkOutput2(string name, logic [3:0] eGnt, logic [1:0] eCid, logic eEn,
                              logic [1:0] eDin, logic eBd);
    compare(name, {gnt2, cur_id2, cons_din_en2, (eEn ? cons_din2 : 2'b00), byte_done2, timeout2},
            {eGnt, eCid, eEn, (eEn ? eDin : 2'b00), eBd, 1'b0});
  endtask

  task automatic applyStimulus(logic rstN, logic [3:0] rq, logic [3:0] en, logic [7:0] din);
    @(negedge clk);
    rst_n      = rstN;
    req        = rq;
    src_din_en = en;
    src_din    = din;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus2(logic [3:0] rq, logic [3:0] en, logic [7:0] din);
    @(negedge clk);
    req2        = rq;
    src_din_en2 = en;
    src_din2    = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] syms2 [8];
    passCount   = 0;
    checkCount  = 0;
    rst_n       = 1'b0;
    req         = '0;
    src_din     = '0;
    src_din_en  = '0;
    req2        = '0;
    src_din2    = '0;
    src_din_en2 = '0;

    // Single source, one byte
    addVec(1, 4'b0001, 4'b0000, 8'h00, 4'b0001, 0, 0, 2'b00, 0);
    addVec(1, 4'b0001, 4'b0001, 8'b00000011, 4'b0001, 0, 1, 2'b11, 0);
    addVec(1, 4'b0001, 4'b0001, 8'b00000000, 4'b0001, 0, 1, 2'b00, 0);
    addVec(1, 4'b0001, 4'b0001, 8'b00000010, 4'b0001, 0, 1, 2'b10, 0);
    addVec(1, 4'b0001, 4'b0001, 8'b00000001, 4'b0000, 0, 1, 2'b01, 1);
    addVec(1, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0, 0, 2'b00, 0);
    addVec(0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0, 0, 2'b00, 0);
    // Full contention after reset: order 0,1,2,3,0; requester k sends symbol k
    for (int g = 0; g < 5; g++) begin
      logic [1:0] k;
      logic [3:0] oh;
      k  = 2'(g % 4);
      oh = 4'b0001 << k;
      addVec(1, 4'b1111, 4'b1111, 8'b11100100, oh, k, 0, 2'b00, 0);
      for (int s = 0; s < 3; s++) addVec(1, 4'b1111, 4'b1111, 8'b11100100, oh, k, 1, k, 0);
      addVec(1, 4'b1111, 4'b1111, 8'b11100100, 4'b0000, k, 1, k, 1);
    end
    addVec(1, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0, 0, 2'b00, 0);
    // Gapped requester 1 while the others keep en high
    addVec(1, 4'b0010, 4'b1101, 8'b11110011, 4'b0010, 1, 0, 2'b00, 0);
    addVec(1, 4'b0010, 4'b1111, 8'b11110111, 4'b0010, 1, 1, 2'b01, 0);
    addVec(1, 4'b0010, 4'b1101, 8'b11111111, 4'b0010, 1, 0, 2'b00, 0);
    addVec(1, 4'b0010, 4'b1111, 8'b11111011, 4'b0010, 1, 1, 2'b10, 0);
    for (int s = 0; s < 3; s++) addVec(1, 4'b0010, 4'b1101, 8'b11111111, 4'b0010, 1, 0, 2'b00, 0);
    addVec(1, 4'b0010, 4'b1111, 8'b11111111, 4'b0010, 1, 1, 2'b11, 0);
    addVec(1, 4'b0010, 4'b1111, 8'b11110011, 4'b0000, 1, 1, 2'b00, 1);
    addVec(1, 4'b0000, 4'b1101, 8'b11111111, 4'b0000, 1, 0, 2'b00, 0);
    // Reset mid-grant of requester 2, then requester 0 wins and sends a full byte
    addVec(1, 4'b0101, 4'b0000, 8'h00, 4'b0100, 2, 0, 2'b00, 0);
    addVec(1, 4'b0101, 4'b0101, 8'b00010010, 4'b0100, 2, 1, 2'b01, 0);
    addVec(1, 4'b0101, 4'b0101, 8'b00110010, 4'b0100, 2, 1, 2'b11, 0);
    addVec(0, 4'b0101, 4'b0101, 8'b00110010, 4'b0000, 0, 0, 2'b00, 0);
    addVec(1, 4'b0101, 4'b0000, 8'h00, 4'b0001, 0, 0, 2'b00, 0);
    addVec(1, 4'b0101, 4'b0001, 8'b00000001, 4'b0001, 0, 1, 2'b01, 0);
    addVec(1, 4'b0101, 4'b0001, 8'b00000010, 4'b0001, 0, 1, 2'b10, 0);
    addVec(1, 4'b0101, 4'b0001, 8'b00000011, 4'b0001, 0, 1, 2'b11, 0);
    addVec(1, 4'b0100, 4'b0001, 8'b00000000, 4'b0000, 0, 1, 2'b00, 1);
    addVec(1, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0, 0, 2'b00, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 4'b0000, 0, 0, 2'b00, 0, 0);
    checkOutput2("reset_state2", 4'b0000, 0, 0, 2'b00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].req, vecs[i].en, vecs[i].din);
      checkOutput($sformatf("vec%0d", i), vecs[i].eGnt, vecs[i].eCid, vecs[i].eEn,
                  vecs[i].eDin, vecs[i].eBd, 1'b0);
    end

    // Stalled grantee: requester 1 (pointer sits at 1 after the last grant to 0)
    applyStimulus(1, 4'b0010, 4'b0000, 8'h00);
    checkOutput("stall_grant", 4'b0010, 1, 0, 2'b00, 0, 0);
    applyStimulus(1, 4'b0010, 4'b0010, 8'b00001000);
    checkOutput("stall_sym1", 4'b0010, 1, 1, 2'b10, 0, 0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      applyStimulus(1, 4'b0010, 4'b0000, 8'h00);
      checkOutput($sformatf("stall_wait%0d", c), 4'b0010, 1, 0, 2'b00, 0, 0);
    end
    applyStimulus(1, 4'b0010, 4'b0000, 8'h00);
    checkOutput("pad1", 4'b0010, 1, 1, 2'b00, 0, 0);
    applyStimulus(1, 4'b0010, 4'b0000, 8'h00);
    checkOutput("pad2", 4'b0010, 1, 1, 2'b00, 0, 0);
    applyStimulus(1, 4'b0000, 4'b0000, 8'h00);
    checkOutput("pad3", 4'b0000, 1, 1, 2'b00, 1, 1);
`else
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1, 4'b0010, 4'b0000, 8'h00);
      checkOutput($sformatf("stall_wait%0d", c), 4'b0010, 1, 0, 2'b00, 0, 0);
    end
    applyStimulus(1, 4'b0010, 4'b0010, 8'b00000100);
    checkOutput("stall_sym2", 4'b0010, 1, 1, 2'b01, 0, 0);
    applyStimulus(1, 4'b0010, 4'b0010, 8'b00001100);
    checkOutput("stall_sym3", 4'b0010, 1, 1, 2'b11, 0, 0);
    applyStimulus(1, 4'b0000, 4'b0010, 8'b00000000);
    checkOutput("stall_sym4", 4'b0000, 1, 1, 2'b00, 1, 0);
`endif
    applyStimulus(1, 4'b0000, 4'b0000, 8'h00);
    checkOutput("stall_idle", 4'b0000, 1, 0, 2'b00, 0, 0);

    // Two bytes per grant; req drops after the 5th symbol
    syms2[0] = 2'b00; syms2[1] = 2'b01; syms2[2] = 2'b10; syms2[3] = 2'b11;
    syms2[4] = 2'b11; syms2[5] = 2'b10; syms2[6] = 2'b01; syms2[7] = 2'b00;
    applyStimulus2(4'b0001, 4'b0000, 8'h00);
    checkOutput2("bpg2_grant", 4'b0001, 0, 0, 2'b00, 0);
    for (int s = 0; s < 8; s++) begin
      applyStimulus2((s < 5) ? 4'b0001 : 4'b0000, 4'b0001, {6'b000000, syms2[s]});
      checkOutput2($sformatf("bpg2_sym%0d", s + 1), (s == 7) ? 4'b0000 : 4'b0001, 0, 1,
                   syms2[s], (s == 3) || (s == 7));
    end
    applyStimulus2(4'b0000, 4'b0000, 8'h00);
    checkOutput2("bpg2_idle", 4'b0000, 0, 0, 2'b00, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
